// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the register-0 constant and the writeback entry type for the
// writeback arbiter and its load queue.
package writeback_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_wb_queue.sv
// Circular load-result queue with per-entry valid bits, WAW squash by address
// and two address lookups over the valid entries.
module wb_queue
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  wb_entry_t     push_entry_i,
  input  logic          pop_i,
  input  logic          squash_i,
  input  logic [AW-1:0] squash_addr_i,
  input  logic [AW-1:0] lookup_a_i,
  input  logic [AW-1:0] lookup_b_i,
  output logic          full_o,
  output logic          empty_o,
  output wb_entry_t     head_o,
  output logic          match_a_o,
  output logic          match_b_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

  // Popped slots drop their valid bit, so lookups can scan every slot.
  always_comb begin
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].addr == lookup_a_i)) match_a_o = 1'b1;
      if (mem_q[i].valid && (mem_q[i].addr == lookup_b_i)) match_b_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && (mem_q[i].addr == squash_addr_i)) mem_q[i].valid <= 1'b0;
      end
      if (pop_i) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PW'(1);
      end
      if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q        <= tail_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, queued load results fill
// idle cycles; registered write port, combinational RAW hazard lookup.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          hazard_a,
  output logic          hazard_b
);

  logic          alu_win;
  logic          ld_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic          match_a;
  logic          match_b;
  wb_entry_t     head;
  wb_entry_t     push_entry;

  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  assign alu_win  = alu_valid && (alu_addr != REG_ZERO);
  assign ld_ready = !q_full && !reset;
  // r0 loads complete the handshake but never occupy a slot.
  assign ld_push  = ld_valid && ld_ready && (ld_addr != REG_ZERO);
  assign q_pop    = !alu_win && !q_empty && !reset;

  // A load landing alongside a younger ALU write to the same register is dead on arrival.
  assign push_entry = '{valid: !(alu_win && (ld_addr == alu_addr)),
                        addr:  ld_addr,
                        data:  ld_data};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (ld_push),
    .push_entry_i (push_entry),
    .pop_i        (q_pop),
    .squash_i     (alu_win),
    .squash_addr_i(alu_addr),
    .lookup_a_i   (rd_addr_a),
    .lookup_b_i   (rd_addr_b),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_o       (head),
    .match_a_o    (match_a),
    .match_b_o    (match_b)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_win) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (!q_empty && head.valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign hazard_a = (rd_addr_a != REG_ZERO) &&
                    ((wr_en_q && (wr_addr_q == rd_addr_a)) || match_a);
  assign hazard_b = (rd_addr_b != REG_ZERO) &&
                    ((wr_en_q && (wr_addr_q == rd_addr_b)) || match_b);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        hazard_a;
  logic        hazard_b;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b)
  );

  // Reference model: pending loads in program order, plus the write-port register.
  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t       mq[$];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit m_haz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_en && (m_addr == a)) return 1'b1;
    foreach (mq[i]) if (mq[i].v && (mq[i].a == a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_en    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      started = 1'b1;
    end else if (started) begin
      bit    alu_ok, ready, push;
      ment_t e;
      alu_ok = alu_valid && (alu_addr != 5'd0);
      ready  = (mq.size() < DEPTH);
      push   = ld_valid && ready && (ld_addr != 5'd0);
      if (alu_ok) begin
        foreach (mq[i]) begin
          if (mq[i].a == alu_addr) begin
            e = mq[i];
            e.v = 1'b0;
            mq[i] = e;
          end
        end
        m_en   = 1'b1;
        m_addr = alu_addr;
        m_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = e.v;
        if (e.v) begin
          m_addr = e.a;
          m_data = e.d;
        end
      end else begin
        m_en = 1'b0;
      end
      if (push) begin
        e.v = !(alu_ok && (ld_addr == alu_addr));
        e.a = ld_addr;
        e.d = ld_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_ld_ready", {31'd0, ld_ready}, {31'd0, (!reset && (mq.size() < DEPTH))});
      chk("model_wr_en", {31'd0, wr_en}, {31'd0, m_en});
      if (m_en) begin
        chk("model_wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
        chk("model_wr_data", wr_data, m_data);
      end
      chk("model_hazard_a", {31'd0, hazard_a}, {31'd0, m_haz(rd_addr_a)});
      chk("model_hazard_b", {31'd0, hazard_b}, {31'd0, m_haz(rd_addr_b)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ldd);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    idle();
    step();
    step();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    reset = 1'b0;

    // ALU only
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    step();
    chk("alu_wr_en", {31'd0, wr_en}, 32'd1);
    chk("alu_wr_addr", {27'd0, wr_addr}, 32'd3);
    chk("alu_wr_data", wr_data, 32'hDEADBEEF);
    idle();
    step();
    chk("alu_idle_wr_en", {31'd0, wr_en}, 32'd0);

    // Contention: load r5 queued behind three ALU writes to r6
    rd_addr_a = 5'd5;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    #1 chk("cont_ld_ready", {31'd0, ld_ready}, 32'd1);
    step();
    drive(1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'd0);
    #1 chk("cont_haz_c1", {31'd0, hazard_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cont_alu_en", {31'd0, wr_en}, 32'd1);
      chk("cont_alu_addr", {27'd0, wr_addr}, 32'd6);
      chk("cont_alu_data", wr_data, 32'h600 + i);
      if (i < 2) drive(1'b1, 5'd6, 32'h601 + i, 1'b0, 5'd0, 32'd0);
      else idle();
      #1 chk("cont_haz_mid", {31'd0, hazard_a}, 32'd1);
    end
    step();
    chk("cont_ld_en", {31'd0, wr_en}, 32'd1);
    chk("cont_ld_addr", {27'd0, wr_addr}, 32'd5);
    chk("cont_ld_data", wr_data, 32'h11);
    chk("cont_haz_retiring", {31'd0, hazard_a}, 32'd1);
    step();
    chk("cont_done_en", {31'd0, wr_en}, 32'd0);
    chk("cont_haz_clear", {31'd0, hazard_a}, 32'd0);

    // Fill the queue while the ALU owns the port
    rd_addr_a = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd9, 32'h900 + i, 1'b1, 5'(i), 32'(i));
      #1 chk("fill_ready_open", {31'd0, ld_ready}, 32'd1);
      step();
    end
    drive(1'b1, 5'd9, 32'h9FF, 1'b0, 5'd0, 32'd0);
    #1 chk("fill_full", {31'd0, ld_ready}, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    #1 chk("fill_pop_no_ready", {31'd0, ld_ready}, 32'd0);
    step();
    chk("fill_pop_en", {31'd0, wr_en}, 32'd1);
    chk("fill_pop_addr", {27'd0, wr_addr}, 32'd1);
    chk("fill_pop_data", wr_data, 32'd1);
    idle();
    #1 chk("fill_ready_back", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("fill_drained", {31'd0, wr_en}, 32'd0);

    // WAW squash on r7
    rd_addr_a = 5'd7;
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'hAA);
    step();
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    #1 chk("waw_haz_queued", {31'd0, hazard_a}, 32'd1);
    step();
    chk("waw_alu_en", {31'd0, wr_en}, 32'd1);
    chk("waw_alu_addr", {27'd0, wr_addr}, 32'd7);
    chk("waw_alu_data", wr_data, 32'hBB);
    idle();
    #1 chk("waw_haz_outstage", {31'd0, hazard_a}, 32'd1);
    step();
    chk("waw_bubble", {31'd0, wr_en}, 32'd0);
    chk("waw_haz_clear", {31'd0, hazard_a}, 32'd0);
    step();
    chk("waw_no_rewrite", {31'd0, wr_en}, 32'd0);

    // Register 0 from both producers
    rd_addr_a = 5'd0;
    drive(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h77);
    #1 chk("r0_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("r0_hazard", {31'd0, hazard_a}, 32'd0);
    step();
    chk("r0_wr_en", {31'd0, wr_en}, 32'd0);
    idle();
    step();
    chk("r0_not_queued", {31'd0, wr_en}, 32'd0);
    chk("r0_ready_after", {31'd0, ld_ready}, 32'd1);

    // Reset with three entries pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 32'h990 + i, 1'b1, 5'(10 + i), 32'hA0 + i);
      step();
    end
    idle();
    reset = 1'b1;
    #1 chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    step();
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    reset = 1'b0;
    #1 chk("mid_rst_ready_back", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_stale", {31'd0, wr_en}, 32'd0);
    end

    // Randomized traffic on a small register range to force collisions
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = 1'($urandom_range(0, 1));
      ld_addr   = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      rd_addr_a = 5'($urandom_range(0, 7));
      rd_addr_b = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the register file's single write port (write enable, write address, write data) from two producers:
  - the ALU result path, single-cycle and never stalled;
  - the load/slow-unit path, which uses a valid/ready handshake.
- Load results are buffered in a small queue and drain into cycles the ALU leaves free.
- Reports which read addresses have a write still pending, so the core can stall on RAW hazards.
- Sits between the execute/memory stages and the register file, in the writeback stage.

Parameters:
- DEPTH, 4, load-queue entries; power of two, >= 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  queue can accept a load result.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load result.
- wr_en  out  1  register-file write enable.
- wr_addr  out  AW  register-file write address.
- wr_data  out  DW  register-file write data.
- rd_addr_a  in  AW  read address A, for hazard lookup.
- rd_addr_b  in  AW  read address B, for hazard lookup.
- hazard_a  out  1  a write to rd_addr_a is pending.
- hazard_b  out  1  a write to rd_addr_b is pending.

Behaviour:
- Reset (already decided): one clock, clk; reset is synchronous and active-high.
  - Reset empties the queue and clears all entry valid bits.
  - wr_en=0, wr_addr=0, wr_data=0.
  - ld_ready=0 while reset is high.
- Output stage: wr_en/wr_addr/wr_data are registered; a result accepted in cycle N appears on the write port in cycle N+1.
- Selection each cycle, in priority order:
  - alu_valid with alu_addr != 0 loads the output stage from the ALU.
  - Otherwise, if the queue is non-empty, pop the head. wr_en takes the head entry's valid bit; a squashed entry produces a bubble (wr_en=0).
  - Otherwise wr_en=0; wr_addr and wr_data hold their previous values.
- Register 0: wr_en is never asserted with wr_addr=0.
  - An ALU result to register 0 is ignored.
  - A load to register 0 completes its handshake but is not enqueued.
- Handshake:
  - ld_ready = !full, computed from the count at the start of the cycle; a same-cycle pop does not raise ld_ready.
  - A transfer occurs when ld_valid && ld_ready; it pushes at the tail and sets the entry's valid bit.
  - Push and pop in the same cycle leave the count unchanged.
- WAW squash: when an ALU write to address R (R != 0) is accepted:
  - every queued entry with address R has its valid bit cleared;
  - a load to R transferring in the same cycle is enqueued already invalid;
  - rationale: in-order issue makes the ALU instruction younger, so its result must not be overwritten.
- Hazard lookup (combinational): hazard_x = 1 when rd_addr_x != 0 and either:
  - the output stage holds wr_en=1 with wr_addr == rd_addr_x; or
  - any valid queue entry has address rd_addr_x.
  - Squashed entries never raise a hazard.
- Counter: width $clog2(DEPTH+1). Head and tail pointers wrap modulo DEPTH. Full when count == DEPTH, empty when count == 0.
- Reset mid-drain: all queued entries are discarded, including valid ones; wr_en=0 on the next cycle.

Decomposition:
- Shared package: AW, DW, REG_ZERO (5'd0), and a writeback-entry struct {valid, addr, data}.
- Sub-module wb_queue: circular buffer with per-entry valid bits. It provides push/pop, an address-match squash input, and two address-match lookup outputs.
- The top level holds the priority mux, the output register and the register-0 filtering.

Test Plan:
- ALU only: alu_valid=1, alu_addr=3, alu_data=0xDEADBEEF in cycle 0 -> wr_en=1, wr_addr=3, wr_data=0xDEADBEEF in cycle 1; wr_en=0 in cycle 2.
- Contention: load to r5=0x11 accepted in cycle 0, ALU to r6 in cycles 1-3 -> r6 writes in cycles 2-4; r5 written in cycle 5; hazard_a=1 for rd_addr_a=5 until that write retires.
- Fill: 4 loads to r1..r4 while the ALU writes every cycle -> ld_ready=0 after the 4th transfer. One idle ALU cycle pops r1; ld_ready returns to 1 the next cycle.
- WAW squash: queued load r7=0xAA, then ALU r7=0xBB -> wr_data=0xBB written once; the r7 entry later pops as a bubble (wr_en=0); hazard on r7 clears after the ALU write retires.
- Register 0: ALU to r0 and load to r0 (ld_ready=1) -> no wr_en; the load handshake completes; count is unchanged; hazard_a=0 for rd_addr_a=0.
- Reset mid-drain: 3 queued entries, then reset for one cycle -> wr_en=0, ld_ready=0 during reset, queue empty; ld_ready=1 and no stale writes after reset deasserts.
